// File: rtl/color_scan_scheduler.sv
// Colour sensor scan sequencer: steps the filter R,B,G,
// gates and counts sensor edges, classifies the dominant colour.
module color_scan_scheduler #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int GATE_CYCLES = 100000,
  parameter int CNT_W = 32,
  parameter int R_OFFSET = 14,
  parameter int B_OFFSET = 11,
  parameter int G_OFFSET = 8,
  parameter logic [1:0] SCALE = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_freq,
  output logic [1:0]       scale,
  output logic [1:0]       filter,
  output logic             busy,
  output logic             done,
  output logic [2:0]       color,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] green_cnt
);

  localparam int TMAX =
    (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, GATE, LATCH, CLASSIFY
  } state_t;

  typedef enum logic [1:0] {
    CH_R, CH_B, CH_G
  } ch_t;

  state_t          state;
  ch_t             ch;
  logic [TW-1:0]   timer;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] sh_r, sh_b, sh_g;
  logic [CNT_W-1:0] off;
  logic [CNT_W-1:0] lat_val;
  logic [2:0]      color_nxt;
  logic            s1, s2, d3;
  logic            rise;
  logic            done_q;

  assign scale = SCALE;
  assign rise  = s2 & ~d3;

  // Two-flop synchronizer plus delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d3 <= 1'b0;
    end else begin
      s1 <= sensor_freq;
      s2 <= s1;
      d3 <= s2;
    end
  end

  // Offset-corrected count for the channel being latched
  always_comb begin
    off = '0;
    unique case (ch)
      CH_R:    off = CNT_W'(R_OFFSET);
      CH_B:    off = CNT_W'(B_OFFSET);
      CH_G:    off = CNT_W'(G_OFFSET);
      default: off = '0;
    endcase
    lat_val = (edge_cnt < off) ? '0 : edge_cnt - off;
  end

  // Dominant colour from the three shadow counts
  always_comb begin
    color_nxt = 3'b000;
    if (sh_r == sh_b && sh_b == sh_g)
      color_nxt = 3'b111;
    else if (sh_r > sh_b && sh_r > sh_g)
      color_nxt = 3'b001;
    else if (sh_b > sh_r && sh_b > sh_g)
      color_nxt = 3'b010;
    else if (sh_g > sh_r && sh_g > sh_b)
      color_nxt = 3'b100;
  end

  // Scan FSM; done trails the output update by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= CH_R;
      timer     <= '0;
      edge_cnt  <= '0;
      filter    <= 2'b10;
      busy      <= 1'b0;
      done_q    <= 1'b0;
      done      <= 1'b0;
      color     <= 3'b000;
      red_cnt   <= '0;
      blue_cnt  <= '0;
      green_cnt <= '0;
      sh_r      <= '0;
      sh_b      <= '0;
      sh_g      <= '0;
    end else begin
      done_q <= 1'b0;
      done   <= done_q;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= SETTLE;
            ch     <= CH_R;
            filter <= 2'b00;
            busy   <= 1'b1;
            timer  <= '0;
          end
        end
        SETTLE: begin
          edge_cnt <= '0;
          if (timer == S_LAST) begin
            timer <= '0;
            state <= GATE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GATE: begin
          if (rise && edge_cnt != '1)
            edge_cnt <= edge_cnt + CNT_W'(1);
          if (timer == G_LAST) begin
            timer <= '0;
            state <= LATCH;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        LATCH: begin
          edge_cnt <= '0;
          unique case (ch)
            CH_R: begin
              sh_r   <= lat_val;
              ch     <= CH_B;
              filter <= 2'b01;
              state  <= SETTLE;
            end
            CH_B: begin
              sh_b   <= lat_val;
              ch     <= CH_G;
              filter <= 2'b11;
              state  <= SETTLE;
            end
            default: begin
              sh_g  <= lat_val;
              state <= CLASSIFY;
            end
          endcase
        end
        CLASSIFY: begin
          red_cnt   <= sh_r;
          blue_cnt  <= sh_b;
          green_cnt <= sh_g;
          color     <= color_nxt;
          done_q    <= 1'b1;
          if (continuous) begin
            state  <= SETTLE;
            ch     <= CH_R;
            filter <= 2'b00;
          end else begin
            state  <= IDLE;
            filter <= 2'b10;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
